// File: rtl/cnt_job_dispatcher.sv
// Job FIFO plus issue/watchdog sequencer feeding the count-FSM.
// Issues start/target, generates the running count, reports tagged completions.
module cnt_job_dispatcher #(
    parameter int CNT_WIDTH  = 7,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int WD_SLACK   = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [CNT_WIDTH-1:0] job_val_i,
    input  logic [TAG_WIDTH-1:0] job_tag_i,
    output logic                 start_o,
    output logic [CNT_WIDTH-1:0] cnt_val_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    input  logic                 run_i,
    input  logic                 done_i,
    output logic                 cmp_valid_o,
    output logic [TAG_WIDTH-1:0] cmp_tag_o,
    output logic                 cmp_err_o,
    output logic                 busy_o,
    output logic [LW-1:0]        level_o
);

    localparam int WDW = CNT_WIDTH + 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_e;

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] val_mem [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic                 full, empty, push, pop;

    logic [CNT_WIDTH-1:0] cnt_val_q, cnt_val_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [WDW-1:0]       wd_q, wd_d;
    logic [WDW-1:0]       wd_lim;
    logic                 err_q, err_d;

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = job_valid_i && !full;
    assign pop   = (state_q == IDLE) && !empty;

    // Power-of-two depth: pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (pop && !push)
                level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            val_mem[wr_ptr_q] <= job_val_i;
            tag_mem[wr_ptr_q] <= job_tag_i;
        end
    end

    // Widened so the largest target cannot overflow the limit.
    assign wd_lim = WDW'(cnt_val_q) + WDW'(WD_SLACK) + WDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_val_q <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_val_q <= cnt_val_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_val_d = cnt_val_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        wd_d      = wd_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d   = ISSUE;
                    cnt_val_d = val_mem[rd_ptr_q];
                    tag_d     = tag_mem[rd_ptr_q];
                    cnt_d     = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                if (run_i && (cnt_q != cnt_val_q))
                    cnt_d = cnt_q + 1'b1;
                if (done_i) begin
                    state_d = REPORT;
                    err_d   = 1'b0;
                end else if (wd_q == wd_lim) begin
                    state_d = REPORT;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign job_ready_o = !full;
    assign start_o     = (state_q == ISSUE);
    assign cnt_val_o   = cnt_val_q;
    assign cnt_o       = cnt_q;
    assign cmp_valid_o = (state_q == REPORT);
    assign cmp_tag_o   = cmp_valid_o ? tag_q : '0;
    assign cmp_err_o   = cmp_valid_o && err_q;
    assign busy_o      = (state_q != IDLE);
    assign level_o     = level_q;

endmodule
